deinterleaver_top: RTL and testbench
====================================

Name: deinterleaver_top

Overview:
- Receive-side block-deinterleaver for the WiMAX PHY channel-coding chain, QPSK, Ncbps=192.
- Accepts the serial interleaved bit stream from the demapper side and writes each bit to its original (pre-interleave) position in a two-bank ping-pong bit buffer.
- Streams each completed 192-bit block out in natural order towards the FEC decoder.
- Valid/ready handshake on both sides; write and read of opposite banks overlap.

Parameters:
- Ncbps, 192, coded bits per block (buffer depth per bank).
- Ncpc, 2, coded bits per carrier (QPSK).
- s, Ncpc/2, second-permutation parameter; only s=1 is supported.
- d, 16, interleaver column count; Ncbps/d=12 rows.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_N  input  1  asynchronous active-low reset.
- data_in  input  1  interleaved serial bit.
- valid_in  input  1  data_in valid.
- ready_out  output  1  block can accept data_in this cycle.
- data_out  output  1  deinterleaved serial bit.
- valid_out  output  1  data_out valid.
- ready_in  input  1  downstream accepts data_out this cycle.

Behaviour:
- One clock (clk); reset_N is asynchronous, active-low. Reset clears all state: both banks EMPTY, counters 0, wr_bank=0, rd_bank=0, data_out=0, valid_out=0, ready_out=1.
- Input transfer occurs on valid_in && ready_out. Output transfer occurs on valid_out && ready_in.
- Write addressing:
  - Input index j=0..191 is held as two counters: jmod (0..11) and jdiv (0..15). Per accepted bit, jmod increments; at 11 it wraps to 0 and jdiv increments.
  - Write address k = 16*jmod + jdiv, 8 bits, no divider. Mapping checks: j=0->0, 1->16, 11->176, 12->1, 191->191.
  - After j=191 the counters wrap to 0, the bank is marked FULL and wr_bank toggles.
- Bank state per bank: EMPTY -> FILLING (first accepted bit) -> FULL (192nd bit) -> DRAINING (first output transfer) -> EMPTY (192nd output transfer).
- ready_out = 1 iff the bank at wr_bank is EMPTY or FILLING. With both banks FULL/DRAINING, ready_out=0.
- Read side:
  - rdaddress 0..191 increments on each output transfer and wraps at 191; rd_bank toggles on wrap.
  - valid_out=1 while the bank at rd_bank is FULL or DRAINING.
- Latency: first valid_out of a block is asserted the cycle after the 192nd input transfer. data_out is registered.
- Backpressure: while valid_out && !ready_in, data_out, valid_out and rdaddress hold unchanged.
- Simultaneous events:
  - The last write into one bank and the last read of the other bank in the same cycle are both honoured.
  - A bank freed by its final read is writable in the next cycle. ready_out may be combinational from bank state registers only.
- valid_in is ignored when ready_out=0; no bits are dropped or overwritten.
- Reset mid-block discards both banks entirely; no partial block is ever output.

Decomposition:
- Shared package wimax_phy_pkg holds:
  - NCBPS=192, D=16, ROWS=12, ADDR_W=8.
  - typedef bank_state_t {EMPTY, FILLING, FULL, DRAINING}.
  - typedef addr_t logic[7:0].
- One sub-module, deint_ppbuffer: the two 192x1 banks, bank states, read counter, and valid_out/ready_out. Write port takes address/data/we; read port takes ready_in.
- deinterleaver_top holds the input handshake and jmod/jdiv address generation.

Test Plan:
- Single-one block: 192 bits with only j=1 set, ready_in=1 -> the output block has only bit k=16 set; first valid_out one cycle after the 192nd input.
- Loopback: 1000 random bits -> interleaver_top -> deinterleaver_top -> output equals input bit-for-bit, in order, with no gaps once streaming.
- Backpressure: ready_in=0 for 400 cycles with valid_in=1 continuous -> ready_out drops after exactly 384 accepted bits; no data lost once ready_in=1.
- Stall mid-drain: ready_in toggled 1/0 every cycle -> data_out stable while stalled; each k emitted exactly once.
- Simultaneous swap: feed block 2's 192nd bit in the same cycle block 1's 192nd bit is read -> both complete; valid_out stays continuous into block 2.
- Reset at j=100 of block 1 -> valid_out=0 and ready_out=1 next cycle; the following full block deinterleaves correctly from j=0.

Source files
------------

// File: rtl/wimax_phy_pkg.sv
// Shared WiMAX PHY constants and types for the QPSK (Ncbps=192) deinterleaver.
// k = D*jmod + jdiv with D=16, so the write address is a plain bit concatenation.
package wimax_phy_pkg;
   localparam int NCBPS  = 192;
   localparam int D      = 16;
   localparam int ROWS   = 12;
   localparam int ADDR_W = 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

   localparam addr_t LAST_ADDR = addr_t'(NCBPS - 1);

   function automatic addr_t wr_addr(input logic [3:0] jmod, input logic [3:0] jdiv);
      return {jmod, jdiv};
   endfunction
endpackage

// File: rtl/deint_ppbuffer.sv
// Two-bank 192x1 ping-pong bit buffer with bank states and a natural-order read counter.
// Output is valid the cycle after a bank fills; data_out, valid_out and rdaddress hold while ready_in is low.
module deint_ppbuffer
   import wimax_phy_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_we,
   input  addr_t i_waddr,
   input  logic  i_wdata,
   input  logic  i_ready_in,
   output logic  o_data_out,
   output logic  o_valid_out,
   output logic  o_ready_out
);
   logic [NCBPS-1:0] r_mem [2];
   bank_state_t      r_state [2];
   bank_state_t      w_state_nxt [2];
   logic             r_wr_bank;
   logic             r_rd_bank;
   addr_t            r_rdaddr;
   logic             r_dout;
   logic             w_we;
   logic             w_wr_last;
   logic             w_fire_out;
   logic             w_rd_last;
   logic             w_nb;
   addr_t            w_na;

   assign o_valid_out = (r_state[r_rd_bank] == FULL) || (r_state[r_rd_bank] == DRAINING);
   assign o_ready_out = (r_state[r_wr_bank] == EMPTY) || (r_state[r_wr_bank] == FILLING);
   assign o_data_out  = r_dout;

   assign w_we       = i_we && o_ready_out;
   assign w_wr_last  = w_we && (i_waddr == LAST_ADDR);
   assign w_fire_out = o_valid_out && i_ready_in;
   assign w_rd_last  = w_fire_out && (r_rdaddr == LAST_ADDR);
   assign w_nb       = r_rd_bank ^ w_rd_last;
   assign w_na       = w_rd_last ? '0 : (w_fire_out ? addr_t'(r_rdaddr + 1'b1) : r_rdaddr);

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         w_state_nxt[b] = r_state[b];
         if (w_we && (r_wr_bank == 1'(b)))
            w_state_nxt[b] = w_wr_last ? FULL : FILLING;
         else if (w_fire_out && (r_rd_bank == 1'(b)))
            w_state_nxt[b] = w_rd_last ? EMPTY : DRAINING;
      end
   end

   // The prefetch reads the next slot every cycle; k=0 is always written long before its bank turns FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state[0] <= EMPTY;
         r_state[1] <= EMPTY;
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_rdaddr   <= '0;
         r_dout     <= 1'b0;
      end else begin
         r_state[0] <= w_state_nxt[0];
         r_state[1] <= w_state_nxt[1];
         if (w_we)
            r_mem[r_wr_bank][i_waddr] <= i_wdata;
         if (w_wr_last)
            r_wr_bank <= ~r_wr_bank;
         r_rd_bank <= w_nb;
         r_rdaddr  <= w_na;
         r_dout    <= r_mem[w_nb][w_na];
      end
   end
endmodule

// File: rtl/deinterleaver_top.sv
// WiMAX QPSK (Ncbps=192) block deinterleaver: input bit j lands at k = 16*(j mod 12) + j/12.
// First valid_out one cycle after a block's last input; ready_out drops only while both banks hold unread blocks.
module deinterleaver_top
   import wimax_phy_pkg::*;
(
   input  logic clk,
   input  logic reset_N,
   input  logic data_in,
   input  logic valid_in,
   output logic ready_out,
   output logic data_out,
   output logic valid_out,
   input  logic ready_in
);
   logic [3:0] r_jmod;
   logic [3:0] r_jdiv;
   logic       w_we;
   addr_t      w_waddr;

   assign w_we    = valid_in && ready_out;
   assign w_waddr = wr_addr(r_jmod, r_jdiv);

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         r_jmod <= '0;
         r_jdiv <= '0;
      end else if (w_we) begin
         if (r_jmod == 4'(ROWS - 1)) begin
            r_jmod <= '0;
            r_jdiv <= (r_jdiv == 4'(D - 1)) ? '0 : r_jdiv + 1'b1;
         end else begin
            r_jmod <= r_jmod + 1'b1;
         end
      end
   end

   deint_ppbuffer u_buf (
      .clk         (clk),
      .rst_n       (reset_N),
      .i_we        (w_we),
      .i_waddr     (w_waddr),
      .i_wdata     (data_in),
      .i_ready_in  (ready_in),
      .o_data_out  (data_out),
      .o_valid_out (valid_out),
      .o_ready_out (ready_out)
   );
endmodule

// File: tb/tb_deinterleaver_top.sv
// Bench for deinterleaver_top: table of single-block vectors plus scoreboarded multi-cycle sequences.
module tb_deinterleaver_top;
   localparam int N = 192;

   logic clk = 1'b0;
   logic reset_N, data_in, valid_in, ready_out, data_out, valid_out, ready_in;

   always #5 clk = ~clk;

   deinterleaver_top dut (
      .clk       (clk),
      .reset_N   (reset_N),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in)
   );

   typedef struct {
      string      name;
      bit [N-1:0] din;
      bit [N-1:0] dexp;
   } vec_t;

   int total = 0;
   int bad = 0;
   bit exp_q[$];
   bit got_q[$];
   bit inbuf[N];
   int in_cnt = 0, acc_cnt = 0, out_pos = 0, gaps = 0, track_target = 0;
   bit in_fire, blk_end_in, blk_end_out, prev_stall, prev_dout, exp_bit;
   bit track = 0, toggle_rdy = 0, seen_valid = 0, swap_seen = 0;

   vec_t       vecs[7];
   bit [N-1:0] one, rv, gv;
   bit [N-1:0] orig[5];
   bit [N-1:0] il[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   task automatic check_vec(input string name, input bit [N-1:0] act, input bit [N-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // One clock: observe at negedge (scoreboard + stall hold), return #1 after the posedge.
   task automatic tick();
      @(negedge clk);
      in_fire = 1'b0; blk_end_in = 1'b0; blk_end_out = 1'b0;
      if (!reset_N) begin
         exp_q.delete();
         in_cnt = 0; out_pos = 0; prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_data_hold", 32'(data_out), 32'(prev_dout));
            check("stall_valid_hold", 32'(valid_out), 1);
         end
         if (valid_out && ready_in) begin
            got_q.push_back(data_out);
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_output: data_out=%0b with empty scoreboard", data_out);
            end else begin
               exp_bit = exp_q.pop_front();
               check("scoreboard_bit", 32'(data_out), 32'(exp_bit));
            end
            blk_end_out = (out_pos == N-1);
            out_pos = blk_end_out ? 0 : out_pos + 1;
         end
         if (valid_in && ready_out) begin
            in_fire = 1'b1; acc_cnt++;
            inbuf[in_cnt] = data_in; in_cnt++;
            if (in_cnt == N) begin
               for (int k = 0; k < N; k++) exp_q.push_back(inbuf[12*(k%16) + k/16]);
               in_cnt = 0; blk_end_in = 1'b1;
            end
         end
         prev_stall = valid_out && !ready_in;
         prev_dout = data_out;
         if (track) begin
            if (valid_out) seen_valid = 1'b1;
            else if (seen_valid && got_q.size() < track_target) gaps++;
            if (blk_end_in && blk_end_out) swap_seen = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (toggle_rdy) ready_in = ~ready_in;
   endtask

   task automatic send_bits(input bit [N-1:0] v, input int n, input bit lat);
      int waited;
      for (int j = 0; j < n; j++) begin
         data_in = v[j]; valid_in = 1'b1; waited = 0;
         if (lat && j == N-1) check("latency_before_last", 32'(valid_out), 0);
         do begin tick(); waited++; end while (!in_fire && waited < 1000);
         if (!in_fire) begin
            total++; bad++;
            $display("FAIL send_timeout: bit %0d not accepted, ready_out=%0b", j, ready_out);
            break;
         end
         if (lat && j == N-1) check("latency_after_last", 32'(valid_out), 1);
      end
      valid_in = 1'b0;
   endtask

   task automatic drain();
      int cyc = 0;
      while ((exp_q.size() != 0 || valid_out) && cyc < 3000) begin tick(); cyc++; end
      if (cyc >= 3000) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d bits still expected, valid_out=%0b", exp_q.size(), valid_out);
      end
   endtask

   task automatic take_block(input int base);
      for (int k = 0; k < N; k++) gv[k] = (base + k < got_q.size()) ? got_q[base + k] : 1'b0;
   endtask

   task automatic rand_vec();
      for (int i = 0; i < N; i++) rv[i] = 1'($urandom_range(0, 1));
   endtask

   initial begin
      one = 1;
      vecs[0].name = "single_j1";    vecs[0].din = one << 1;   vecs[0].dexp = one << 16;
      vecs[1].name = "single_j0";    vecs[1].din = one;        vecs[1].dexp = one;
      vecs[2].name = "single_j11";   vecs[2].din = one << 11;  vecs[2].dexp = one << 176;
      vecs[3].name = "single_j12";   vecs[3].din = one << 12;  vecs[3].dexp = one << 1;
      vecs[4].name = "single_j191";  vecs[4].din = one << 191; vecs[4].dexp = one << 191;
      vecs[5].name = "pair_j13_190"; vecs[5].din = (one << 13) | (one << 190);
      vecs[5].dexp = (one << 17) | (one << 175);
      vecs[6].name = "all_ones";     vecs[6].din = ~'0;        vecs[6].dexp = ~'0;

      reset_N = 1'b0; data_in = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
      repeat (3) tick();
      check("reset_valid_out", 32'(valid_out), 0);
      check("reset_ready_out", 32'(ready_out), 1);
      check("reset_data_out", 32'(data_out), 0);
      reset_N = 1'b1;
      tick();

      foreach (vecs[i]) begin
         got_q.delete();
         send_bits(vecs[i].din, N, i == 0);
         drain();
         check({vecs[i].name, "_count"}, got_q.size(), N);
         take_block(0);
         check_vec(vecs[i].name, gv, vecs[i].dexp);
      end

      // ready_in toggles every cycle while a block drains
      got_q.delete();
      rand_vec();
      send_bits(rv, N, 1'b0);
      toggle_rdy = 1'b1;
      drain();
      toggle_rdy = 1'b0; ready_in = 1'b1;
      check("stall_drain_count", got_q.size(), N);

      // downstream blocked: exactly two blocks fit before ready_out drops
      got_q.delete();
      ready_in = 1'b0; valid_in = 1'b1; acc_cnt = 0;
      for (int c = 0; c < 400; c++) begin
         data_in = 1'($urandom_range(0, 1));
         tick();
      end
      check("backpressure_accepted", acc_cnt, 2*N);
      check("backpressure_ready_out", 32'(ready_out), 0);
      valid_in = 1'b0; ready_in = 1'b1;
      drain();
      check("backpressure_drained", got_q.size(), 2*N);

      // loopback of five interleaved blocks, streamed back to back
      for (int b = 0; b < 5; b++) begin
         rand_vec();
         orig[b] = rv;
         for (int k = 0; k < N; k++) il[b][12*(k%16) + k/16] = orig[b][k];
      end
      got_q.delete();
      gaps = 0; seen_valid = 1'b0; swap_seen = 1'b0; track_target = 5*N; track = 1'b1;
      for (int b = 0; b < 5; b++) send_bits(il[b], N, 1'b0);
      drain();
      track = 1'b0;
      check("loopback_count", got_q.size(), 5*N);
      check("loopback_gap_cycles", gaps, 0);
      check("simultaneous_swap_seen", 32'(swap_seen), 1);
      for (int b = 0; b < 5; b++) begin
         take_block(b*N);
         check_vec($sformatf("loopback_block%0d", b), gv, orig[b]);
      end

      // reset with one full block pending and the next at j=100
      ready_in = 1'b0;
      rand_vec();
      send_bits(rv, N, 1'b0);
      rand_vec();
      send_bits(rv, 100, 1'b0);
      check("pre_reset_valid_out", 32'(valid_out), 1);
      reset_N = 1'b0;
      #1;
      check("midreset_valid_out", 32'(valid_out), 0);
      check("midreset_ready_out", 32'(ready_out), 1);
      tick();
      tick();
      reset_N = 1'b1; ready_in = 1'b1;
      got_q.delete();
      send_bits(vecs[0].din, N, 1'b1);
      drain();
      check("post_reset_count", got_q.size(), N);
      take_block(0);
      check_vec("post_reset_single_j1", gv, vecs[0].dexp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
